// File: rtl/transpose_fifo_seq.sv
//==============================================================================
// transpose_fifo_seq: loads DIM rows into the transpose FIFOs, then issues
// skewed shift enables and keeps the systolic array running.  Rev 1.0
//==============================================================================
`default_nettype none

module transpose_fifo_seq #(
  parameter int DIM = 8,
  parameter int CW  = $clog2(3*DIM)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           clear,
  input  logic           row_valid,
  output logic           row_ready,
  output logic [DIM-1:0] wr_en,
  output logic [DIM-1:0] shift_en,
  output logic           array_en,
  output logic           busy,
  output logic           done
);

  localparam int            RW       = $clog2(DIM);
  localparam logic [CW-1:0] C_LAST   = CW'(3*DIM-2);
  localparam logic [RW-1:0] ROW_LAST = RW'(DIM-1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] row_cnt_q, row_cnt_d;
  logic [CW-1:0] c_q, c_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      row_cnt_q <= '0;
      c_q       <= '0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      c_q       <= c_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    c_d       = c_q;
    if (clear) begin
      state_d   = S_IDLE;
      row_cnt_d = '0;
      c_d       = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d   = S_LOAD;
            row_cnt_d = '0;
          end
        end
        S_LOAD: begin
          if (row_valid) begin
            if (row_cnt_q == ROW_LAST) begin
              state_d   = S_RUN;
              row_cnt_d = '0;
              c_d       = '0;
            end else begin
              row_cnt_d = row_cnt_q + RW'(1);
            end
          end
        end
        S_RUN: begin
          // Run long enough for the last partial product to drain out of the array.
          if (c_q == C_LAST) begin
            state_d = S_DONE;
            c_d     = '0;
          end else begin
            c_d = c_q + CW'(1);
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    row_ready = (state_q == S_LOAD);
    array_en  = (state_q == S_RUN);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    wr_en     = '0;
    if ((state_q == S_LOAD) && row_valid) begin
      wr_en[row_cnt_q] = 1'b1;
    end
  end

  // FIFO i joins the wavefront i cycles after FIFO 0 and shifts to the end of the run.
  genvar gi;
  generate
    for (gi = 0; gi < DIM; gi++) begin : g_shift
      assign shift_en[gi] = (state_q == S_RUN) && (c_q >= CW'(gi));
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_transpose_fifo_seq.sv
//==============================================================================
// tb_transpose_fifo_seq: randomized self-checking bench against a timeline
// model of the load/run/done sequence.  Rev 1.0
//==============================================================================
`default_nettype none

module tb_transpose_fifo_seq;

  localparam int D  = 8;
  localparam int VW = 2*D + 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         clear = 1'b0;
  logic         row_valid = 1'b0;
  logic         row_ready;
  logic [D-1:0] wr_en;
  logic [D-1:0] shift_en;
  logic         array_en;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_err = 0;

  // Scenario description: per-cycle input patterns and derived milestones.
  bit vpat [0:255];
  bit spat [0:255];
  int clr_k;
  int last_k;   // cycle in which the final row is accepted
  int end_k;    // last busy cycle (done cycle, or the clear cycle)

  transpose_fifo_seq #(.DIM(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .clear     (clear),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .wr_en     (wr_en),
    .shift_en  (shift_en),
    .array_en  (array_en),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] act_vec();
    return {row_ready, wr_en, shift_en, array_en, busy, done};
  endfunction

  // Expected outputs at scenario cycle k (start presented at k=0):
  // load during 1..last_k, run for 3D-1 cycles, done one cycle later.
  function automatic logic [VW-1:0] exp_vec(int k);
    logic rr, ae, bs, dn;
    logic [D-1:0] we, se;
    int acc;
    rr = 0; ae = 0; bs = 0; dn = 0; we = '0; se = '0;
    if (k >= 1 && k <= last_k && k <= end_k) begin
      rr = 1; bs = 1;
      if (vpat[k]) begin
        acc = 0;
        for (int j = 1; j < k; j++) acc += int'(vpat[j]);
        we[acc] = 1'b1;
      end
    end else if (k > last_k && k < last_k + 3*D && k <= end_k) begin
      ae = 1; bs = 1;
      for (int i = 0; i < D; i++) se[i] = ((k - last_k - 1) >= i);
    end else if (k == last_k + 3*D && k <= end_k) begin
      bs = 1; dn = 1;
    end
    return {rr, we, se, ae, bs, dn};
  endfunction

  // mode 0: back-to-back, 1: random valid; valid forced low over [lo_a, lo_b].
  task automatic prep(input int mode, input int lo_a, input int lo_b,
                      input bit spam, input int clear_c);
    int rows;
    for (int k = 0; k < 256; k++) begin
      vpat[k] = (mode == 0 || k >= 60) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (k >= lo_a && k <= lo_b) vpat[k] = 1'b0;
      spat[k] = 1'b0;
    end
    vpat[0] = 1'b0;
    spat[0] = 1'b1;
    rows = 0;
    last_k = 0;
    for (int k = 1; k < 256 && rows < D; k++) begin
      if (vpat[k]) begin
        rows++;
        if (rows == D) last_k = k;
      end
    end
    clr_k = (clear_c >= 0) ? last_k + 1 + clear_c : -1;
    end_k = (clr_k >= 0) ? clr_k : last_k + 3*D;
    if (spam)
      for (int k = 1; k <= end_k; k++) spat[k] = ($urandom_range(0, 2) == 0);
  endtask

  task automatic drive(input int k);
    start     = spat[k];
    row_valid = vpat[k];
    clear     = (k == clr_k);
  endtask

  task automatic idle_inputs();
    start = 0; row_valid = 0; clear = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; row_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (act_vec() !== '0) begin
        n_err++;
        $display("FAIL reset k=%0d got=%h exp=0", k, act_vec());
      end
    end
    idle_inputs();
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (act_vec() !== '0) begin
        n_err++;
        $display("FAIL idle_after_reset k=%0d got=%h exp=0", k, act_vec());
      end
    end
  endtask

  task automatic test_back_to_back();
    prep(0, -1, -1, 1'b0, -1);
    for (int k = 0; k <= end_k + 2; k++) begin
      @(negedge clk); drive(k); #1;
      n_cmp++;
      if (act_vec() !== exp_vec(k)) begin
        n_err++;
        $display("FAIL back_to_back k=%0d got=%h exp=%h", k, act_vec(), exp_vec(k));
      end
    end
    idle_inputs();
  endtask

  task automatic test_valid_stall();
    prep(0, 3, 5, 1'b0, -1);
    for (int k = 0; k <= end_k + 2; k++) begin
      @(negedge clk); drive(k); #1;
      n_cmp++;
      if (act_vec() !== exp_vec(k)) begin
        n_err++;
        $display("FAIL valid_stall k=%0d got=%h exp=%h", k, act_vec(), exp_vec(k));
      end
    end
    idle_inputs();
  endtask

  task automatic test_start_ignored();
    prep(1, -1, -1, 1'b1, -1);
    for (int k = 0; k <= end_k + 3; k++) begin
      @(negedge clk); drive(k); #1;
      n_cmp++;
      if (act_vec() !== exp_vec(k)) begin
        n_err++;
        $display("FAIL start_ignored k=%0d got=%h exp=%h", k, act_vec(), exp_vec(k));
      end
    end
    idle_inputs();
  endtask

  task automatic test_clear();
    prep(1, -1, -1, 1'b0, 5);
    for (int k = 0; k <= end_k + 3; k++) begin
      @(negedge clk); drive(k); #1;
      n_cmp++;
      if (act_vec() !== exp_vec(k)) begin
        n_err++;
        $display("FAIL clear_run k=%0d got=%h exp=%h", k, act_vec(), exp_vec(k));
      end
    end
    idle_inputs();
    prep(1, -1, -1, 1'b0, -1);
    for (int k = 0; k <= end_k + 2; k++) begin
      @(negedge clk); drive(k); #1;
      n_cmp++;
      if (act_vec() !== exp_vec(k)) begin
        n_err++;
        $display("FAIL after_clear k=%0d got=%h exp=%h", k, act_vec(), exp_vec(k));
      end
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    prep(0, -1, -1, 1'b0, -1);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk); drive(k); #1;
      n_cmp++;
      if (act_vec() !== exp_vec(k)) begin
        n_err++;
        $display("FAIL pre_reset_load k=%0d got=%h exp=%h", k, act_vec(), exp_vec(k));
      end
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (act_vec() !== '0) begin
      n_err++;
      $display("FAIL async_reset_immediate got=%h exp=0", act_vec());
    end
    @(negedge clk); #1;
    n_cmp++;
    if (act_vec() !== '0) begin
      n_err++;
      $display("FAIL async_reset_held got=%h exp=0", act_vec());
    end
    idle_inputs();
    rst_n = 1'b1;
    prep(1, -1, -1, 1'b0, -1);
    for (int k = 0; k <= end_k + 2; k++) begin
      @(negedge clk); drive(k); #1;
      n_cmp++;
      if (act_vec() !== exp_vec(k)) begin
        n_err++;
        $display("FAIL after_async_reset k=%0d got=%h exp=%h", k, act_vec(), exp_vec(k));
      end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      prep(1, -1, -1, ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3*D-2)) : -1);
      for (int k = 0; k <= end_k + 2; k++) begin
        @(negedge clk); drive(k); #1;
        n_cmp++;
        if (act_vec() !== exp_vec(k)) begin
          n_err++;
          $display("FAIL random%0d k=%0d got=%h exp=%h", n, k, act_vec(), exp_vec(k));
        end
      end
      idle_inputs();
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_valid_stall();
    test_start_ignored();
    test_clear();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/transpose_fifo_seq.md
# transpose_fifo_seq

Sequencer for the bank of DIM transpose FIFOs that feed the systolic matrix-multiply array. It accepts DIM matrix rows over a valid/ready port and parallel-loads each row into its own FIFO. It then issues skewed shift enables so the FIFO outputs form the diagonal wavefront the array expects, keeps the array enabled until the last partial product has propagated, and signals completion. It drives control only; row data is routed straight to the FIFOs' rowIn, and each FIFO's serial input d is tied to 0.

## Interface
- DIM, 8: number of transpose FIFOs and matrix dimension; must be ≥2.
- CW, $clog2(3*DIM): width of the internal run counter.

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a load/run sequence; sampled only in IDLE
- clear  in  1  synchronous abort to IDLE; highest priority after reset
- row_valid  in  1  a row is present on the shared row bus
- row_ready  out  1  controller will accept a row this cycle
- wr_en  out  DIM  one-hot parallel-load strobe; bit k loads FIFO k
- shift_en  out  DIM  per-FIFO shift enable (FIFO en input)
- array_en  out  1  systolic array compute enable
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, LOAD, RUN, DONE. Registered state, a row counter row_cnt (0..DIM-1) and a run counter c (0..3*DIM-2).
- IDLE: all outputs 0. If start=1, go to LOAD with row_cnt=0.
- LOAD: row_ready=1.
  - A row is accepted when row_valid=1; that cycle wr_en[row_cnt]=1 and row_cnt increments.
  - When row_valid=0, no strobe is issued, the counters hold, and the controller waits with no timeout.
  - Accepting row DIM-1 moves the controller to RUN with c=0.
- RUN:
  - shift_en[i] = (c ≥ i). FIFO i starts shifting i cycles after FIFO 0 and keeps shifting to the end of the run, pushing zeros in via d=0.
  - array_en=1 in every RUN cycle.
  - c increments every cycle. At c=3*DIM-2 the controller moves to DONE.
- DONE: done=1 and busy=1 for one cycle; all other outputs 0. Next state is IDLE.
- start is ignored outside IDLE, including in DONE.
- clear=1 in any state: next state is IDLE and both counters reset. Outputs in the clear cycle follow the current state; FIFO contents are not cleared.
- Output decode:
  - wr_en is combinational from state, row_cnt and row_valid.
  - All other outputs are combinational from registered state and counters only.
- Invariants:
  - wr_en is one-hot or zero.
  - wr_en and shift_en are never both nonzero in the same cycle.
  - row_ready implies busy.

## Timing
- Reset (async assert, sync deassert into IDLE): state=IDLE, row_cnt=0, c=0. All outputs 0 (row_ready, wr_en, shift_en, array_en, busy, done).
- start sampled at cycle T: busy=1 and row_ready=1 from T+1.
- With back-to-back row_valid, rows are accepted at T+1..T+DIM.
- Last row accepted at cycle L:
  - RUN spans L+1..L+3*DIM-1, i.e. 3*DIM-1 cycles.
  - shift_en[0] rises at L+1; shift_en[DIM-1] rises at L+DIM.
  - DONE (done=1) at L+3*DIM; IDLE at L+3*DIM+1.
- Minimum start-to-done is DIM+3*DIM cycles (4*DIM; 32 for DIM=8).
- row_valid dropping mid-load stalls LOAD 1:1; RUN timing is unaffected.
- Reset asserted mid-operation returns to IDLE immediately (async), with all outputs 0.

## Test plan
- Reset, then start=1 at cycle 1 with row_valid held high (DIM=8) -> wr_en = 0x01,0x02,…,0x80 in cycles 2–9; shift_en = 0x01,0x03,…,0xFF in cycles 10–17, then 0xFF through cycle 32; array_en=1 in cycles 10–32; done=1 only in cycle 33; busy=0 in cycle 34.
- LOAD with row_valid low in cycles 4–6 -> no wr_en bits in those cycles, row_ready stays 1, the 8 rows are still loaded once each in order, and done arrives 3 cycles later than in the back-to-back case.
- start pulses during LOAD, RUN and DONE -> no effect: identical cycle trace to the single-start run, and no second sequence starts.
- clear=1 at RUN cycle c=5 -> IDLE next cycle with all outputs 0 and no done pulse; a subsequent start runs a full sequence normally.
- rst_n asserted asynchronously mid-LOAD (after 3 rows) -> outputs 0 immediately; after release, start loads 8 fresh rows beginning with wr_en=0x01.
- Integration with 8 transpose FIFOs and the array, A = I (identity), B = known matrix -> array results equal B, and done coincides with the final result being valid.
